// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, PC select and the hazard unit FSM encoding,
// plus the load-use detection helper.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pcselect_t;

  localparam logic [1:0] HS_RUN        = 2'd0;
  localparam logic [1:0] HS_DWAIT      = 2'd1;
  localparam logic [1:0] HS_REDIR_PEND = 2'd2;
  localparam logic [1:0] HS_HALTED     = 2'd3;

  typedef enum logic [1:0] {
    RUN        = HS_RUN,
    DWAIT      = HS_DWAIT,
    REDIR_PEND = HS_REDIR_PEND,
    HALTED     = HS_HALTED
  } hazard_state_t;

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  function automatic logic load_use_hazard(
    input logic     ex_dREN,
    input logic     ex_WEN,
    input regbits_t ex_wsel,
    input regbits_t id_rs,
    input regbits_t id_rt,
    input logic     id_uses_rt
  );
    return ex_dREN & ex_WEN & (ex_wsel != 5'd0) &
           ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Latch enable/flush interface between the hazard unit (hu, controlling end)
// and the datapath (dp), together with the status inputs the unit observes.
interface hazard_unit_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dREN;
  logic     mem_dWEN;
  logic     ex_dREN;
  logic     ex_WEN;
  regbits_t ex_wsel;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     id_uses_rt;
  logic     ex_redirect;
  logic     mem_halt;

  logic     pc_enable;
  logic     ifid_enable;
  logic     idex_enable;
  logic     exmem_enable;
  logic     memwb_enable;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     halt;

  modport hu (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_WEN, ex_wsel,
           id_rs, id_rt, id_uses_rt, ex_redirect, mem_halt,
    output pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt
  );

  modport dp (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_WEN, ex_wsel,
           id_rs, id_rt, id_uses_rt, ex_redirect, mem_halt,
    input  pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt
  );

endinterface

// File: rtl/hazard_unit_perf_counter.sv
// Saturating event counter: counts cycles with en=1, sticks at all-ones.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Increment on enable until the counter is full.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller for the 5-stage MIPS datapath.
// Optional performance counters are built when PERF_CNT_EN is defined.
module hazard_unit
  import cpu_types_pkg::*;
`ifdef PERF_CNT_EN
#(
  parameter int CNT_W = 32
)
`endif
(
  input  logic             CLK,
  input  logic             nRST,
  hazard_unit_if.hu        hu
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  hazard_state_t state_r, state_next_s;
  // pend_r: redirect already flushed, PC target load still owed.
  // seen_r: redirect observed during a data wait, flush not yet applied.
  logic pend_r, pend_next_s;
  logic seen_r, seen_next_s;

  logic dwait_s, redir_s, load_use_s;
  logic pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s;
  logic ifid_fl_s, idex_fl_s, exmem_fl_s, memwb_fl_s, halt_s;

  assign dwait_s    = (hu.mem_dREN | hu.mem_dWEN) & ~hu.dhit;
  assign redir_s    = hu.ex_redirect | pend_r | seen_r;
  assign load_use_s = load_use_hazard(hu.ex_dREN, hu.ex_WEN, hu.ex_wsel,
                                      hu.id_rs, hu.id_rt, hu.id_uses_rt);

  // Latch control, resolved in priority order halt > data wait > redirect > load-use > fetch wait.
  always_comb begin
    pc_en_s    = hu.ihit;
    ifid_en_s  = 1'b1;
    idex_en_s  = 1'b1;
    exmem_en_s = 1'b1;
    memwb_en_s = 1'b1;
    ifid_fl_s  = 1'b0;
    idex_fl_s  = 1'b0;
    exmem_fl_s = 1'b0;
    memwb_fl_s = 1'b0;
    halt_s     = 1'b0;
    if (!nRST) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
      ifid_fl_s  = 1'b1;
      idex_fl_s  = 1'b1;
      exmem_fl_s = 1'b1;
      memwb_fl_s = 1'b1;
    end else if (state_r == HALTED) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_en_s = 1'b0;
      halt_s     = 1'b1;
    end else if (dwait_s) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_en_s  = 1'b0;
      exmem_en_s = 1'b0;
      memwb_fl_s = 1'b1;
    end else if (redir_s) begin
      // idex is flushed only by a redirect that has not been flushed yet
      pc_en_s    = hu.ihit;
      ifid_fl_s  = 1'b1;
      idex_fl_s  = hu.ex_redirect | seen_r;
    end else if (load_use_s) begin
      pc_en_s    = 1'b0;
      ifid_en_s  = 1'b0;
      idex_fl_s  = 1'b1;
    end else if (!hu.ihit) begin
      pc_en_s    = 1'b0;
      ifid_fl_s  = 1'b1;
    end else begin
      pc_en_s    = 1'b1;
    end
  end

  assign hu.pc_enable    = pc_en_s;
  assign hu.ifid_enable  = ifid_en_s;
  assign hu.idex_enable  = idex_en_s;
  assign hu.exmem_enable = exmem_en_s;
  assign hu.memwb_enable = memwb_en_s;
  assign hu.ifid_flush   = ifid_fl_s;
  assign hu.idex_flush   = idex_fl_s;
  assign hu.exmem_flush  = exmem_fl_s;
  assign hu.memwb_flush  = memwb_fl_s;
  assign hu.halt         = halt_s;

  // Next-state and redirect bookkeeping.
  always_comb begin
    state_next_s = state_r;
    pend_next_s  = pend_r;
    seen_next_s  = seen_r;
    case (state_r)
      HALTED: begin
        state_next_s = HALTED;
        pend_next_s  = 1'b0;
        seen_next_s  = 1'b0;
      end
      RUN, DWAIT, REDIR_PEND: begin
        if (dwait_s) begin
          // a halt waiting in MEM is re-evaluated once the access completes
          state_next_s = DWAIT;
          seen_next_s  = seen_r | hu.ex_redirect;
        end else if (hu.mem_halt) begin
          state_next_s = HALTED;
          pend_next_s  = 1'b0;
          seen_next_s  = 1'b0;
        end else if (redir_s) begin
          seen_next_s = 1'b0;
          if (hu.ihit) begin
            state_next_s = RUN;
            pend_next_s  = 1'b0;
          end else begin
            state_next_s = REDIR_PEND;
            pend_next_s  = 1'b1;
          end
        end else begin
          state_next_s = RUN;
          pend_next_s  = 1'b0;
          seen_next_s  = 1'b0;
        end
      end
      default: begin
        state_next_s = RUN;
        pend_next_s  = 1'b0;
        seen_next_s  = 1'b0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= RUN;
      pend_r  <= 1'b0;
      seen_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
      seen_r  <= seen_next_s;
    end
  end

`ifdef PERF_CNT_EN
  logic live_s, stall_s, flush_s;

  assign live_s  = (state_r != HALTED);
  assign stall_s = live_s & ~(pc_en_s & ifid_en_s & idex_en_s & exmem_en_s & memwb_en_s);
  assign flush_s = live_s & (ifid_fl_s | idex_fl_s | exmem_fl_s | memwb_fl_s);

  perf_counter #(.W(CNT_W)) u_cycle_cnt (.CLK(CLK), .nRST(nRST), .en(live_s),  .cnt(cycle_cnt));
  perf_counter #(.W(CNT_W)) u_stall_cnt (.CLK(CLK), .nRST(nRST), .en(stall_s), .cnt(stall_cnt));
  perf_counter #(.W(CNT_W)) u_flush_cnt (.CLK(CLK), .nRST(nRST), .en(flush_s), .cnt(flush_cnt));
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// traffic against a priority-rule reference model.
module tb_hazard_unit;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  int   total  = 0;
  int   passed = 0;

  // Output vector: {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl, halt}
  localparam logic [9:0] V_RUN      = 10'b1_1111_0000_0;
  localparam logic [9:0] V_RST      = 10'b0_0000_1111_0;
  localparam logic [9:0] V_LU       = 10'b0_0111_0100_0;
  localparam logic [9:0] V_DW       = 10'b0_0001_0001_0;
  localparam logic [9:0] V_RD_MISS  = 10'b0_1111_1100_0;
  localparam logic [9:0] V_RD_HIT   = 10'b1_1111_1100_0;
  localparam logic [9:0] V_PND_MISS = 10'b0_1111_1000_0;
  localparam logic [9:0] V_PND_HIT  = 10'b1_1111_1000_0;
  localparam logic [9:0] V_FWAIT    = 10'b0_1111_1000_0;
  localparam logic [9:0] V_HALT     = 10'b0_0000_0000_1;

  hazard_unit_if hif();

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

  hazard_unit dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hu   (hif)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt (cycle_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] obs();
    return {hif.pc_enable, hif.ifid_enable, hif.idex_enable, hif.exmem_enable, hif.memwb_enable,
            hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush, hif.halt};
  endfunction

  task automatic set_idle();
    hif.ihit = 1'b1; hif.dhit = 1'b0; hif.mem_dREN = 1'b0; hif.mem_dWEN = 1'b0;
    hif.ex_dREN = 1'b0; hif.ex_WEN = 1'b0; hif.ex_wsel = 5'd0; hif.id_rs = 5'd0;
    hif.id_rt = 5'd0; hif.id_uses_rt = 1'b0; hif.ex_redirect = 1'b0; hif.mem_halt = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic apply_reset();
    set_idle();
    nRST = 1'b0;
    @(negedge CLK);
    next_cycle();
    nRST = 1'b1;
  endtask

  // Reference: the highest-priority active event selects the output pattern.
  function automatic logic [9:0] model_out(input logic halted, input logic pend, input logic seen);
    logic dw, lu, rd;
    dw = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
    lu = hif.ex_dREN && hif.ex_WEN && (hif.ex_wsel != 5'd0) &&
         ((hif.ex_wsel == hif.id_rs) || (hif.id_uses_rt && (hif.ex_wsel == hif.id_rt)));
    rd = hif.ex_redirect || pend || seen;
    if (halted)     return V_HALT;
    if (dw)         return V_DW;
    if (rd)         return {hif.ihit, 4'b1111, 1'b1, (hif.ex_redirect || seen), 3'b000};
    if (lu)         return V_LU;
    if (!hif.ihit)  return V_FWAIT;
    return V_RUN;
  endfunction

  task automatic test_reset();
    set_idle();
    nRST = 1'b0;
    @(negedge CLK);
    total++; if (obs() !== V_RST) $display("FAIL reset_hold: got %b want %b", obs(), V_RST); else passed++;
`ifdef PERF_CNT_EN
    total++; if (cycle_cnt !== 32'd0) $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt); else passed++;
`endif
    next_cycle();
    nRST = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL reset_release: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
  endtask

  task automatic test_load_use();
    apply_reset();
    hif.ex_dREN = 1'b1; hif.ex_WEN = 1'b1; hif.ex_wsel = 5'd8; hif.id_rs = 5'd8;
    @(negedge CLK);
    total++; if (obs() !== V_LU) $display("FAIL load_use_stall: got %b want %b", obs(), V_LU); else passed++;
    next_cycle();
    hif.ex_dREN = 1'b0; hif.ex_WEN = 1'b0; hif.mem_dREN = 1'b1; hif.dhit = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL load_use_release: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
    set_idle();
    hif.ex_dREN = 1'b1; hif.ex_WEN = 1'b1; hif.ex_wsel = 5'd0; hif.id_rs = 5'd0;
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL load_use_r0: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
    hif.ex_wsel = 5'd9; hif.id_rs = 5'd3; hif.id_rt = 5'd9; hif.id_uses_rt = 1'b0;
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL load_use_rt_unused: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
    hif.id_uses_rt = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_LU) $display("FAIL load_use_rt: got %b want %b", obs(), V_LU); else passed++;
    next_cycle();
    set_idle();
  endtask

  task automatic test_fetch_wait();
    apply_reset();
    hif.ihit = 1'b0;
    @(negedge CLK);
    total++; if (obs() !== V_FWAIT) $display("FAIL fetch_wait: got %b want %b", obs(), V_FWAIT); else passed++;
    next_cycle();
    set_idle();
  endtask

  task automatic test_data_wait();
    apply_reset();
    hif.mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total++; if (obs() !== V_DW) $display("FAIL dwait_cycle%0d: got %b want %b", i, obs(), V_DW); else passed++;
      next_cycle();
    end
    hif.dhit = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL dwait_dhit: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
    set_idle();
    hif.mem_dWEN = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_DW) $display("FAIL dwait_store: got %b want %b", obs(), V_DW); else passed++;
    next_cycle();
    set_idle();
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL dwait_after: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
  endtask

  task automatic test_redirect_pend();
    apply_reset();
    hif.ex_redirect = 1'b1; hif.ihit = 1'b0;
    @(negedge CLK);
    total++; if (obs() !== V_RD_MISS) $display("FAIL redir_miss: got %b want %b", obs(), V_RD_MISS); else passed++;
    next_cycle();
    hif.ex_redirect = 1'b0;
    @(negedge CLK);
    total++; if (obs() !== V_PND_MISS) $display("FAIL redir_pend_hold: got %b want %b", obs(), V_PND_MISS); else passed++;
    next_cycle();
    hif.ihit = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_PND_HIT) $display("FAIL redir_pend_hit: got %b want %b", obs(), V_PND_HIT); else passed++;
    next_cycle();
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL redir_pend_done: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
    hif.ex_redirect = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_RD_HIT) $display("FAIL redir_hit: got %b want %b", obs(), V_RD_HIT); else passed++;
    next_cycle();
    set_idle();
  endtask

  task automatic test_redirect_load_use();
    apply_reset();
    hif.ex_redirect = 1'b1;
    hif.ex_dREN = 1'b1; hif.ex_WEN = 1'b1; hif.ex_wsel = 5'd5; hif.id_rs = 5'd5;
    @(negedge CLK);
    total++; if (obs() !== V_RD_HIT) $display("FAIL redir_lu: got %b want %b", obs(), V_RD_HIT); else passed++;
    next_cycle();
    set_idle();
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL redir_lu_nostall: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
  endtask

  task automatic test_redirect_in_dwait();
    apply_reset();
    hif.mem_dREN = 1'b1; hif.ex_redirect = 1'b1; hif.ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total++; if (obs() !== V_DW) $display("FAIL dw_redir_wait%0d: got %b want %b", i, obs(), V_DW); else passed++;
      next_cycle();
    end
    hif.dhit = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_RD_MISS) $display("FAIL dw_redir_release: got %b want %b", obs(), V_RD_MISS); else passed++;
    next_cycle();
    set_idle(); hif.ihit = 1'b0;
    @(negedge CLK);
    total++; if (obs() !== V_PND_MISS) $display("FAIL dw_redir_pend: got %b want %b", obs(), V_PND_MISS); else passed++;
    next_cycle();
    hif.ihit = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_PND_HIT) $display("FAIL dw_redir_hit: got %b want %b", obs(), V_PND_HIT); else passed++;
    next_cycle();
    set_idle();
  endtask

  task automatic test_halt();
`ifdef PERF_CNT_EN
    logic [31:0] c0;
`endif
    apply_reset();
    hif.mem_halt = 1'b1; hif.mem_dREN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total++; if (obs() !== V_DW) $display("FAIL halt_dwait%0d: got %b want %b", i, obs(), V_DW); else passed++;
      next_cycle();
    end
    hif.dhit = 1'b1;
    @(negedge CLK);
    total++; if (obs() !== V_RUN) $display("FAIL halt_dhit: got %b want %b", obs(), V_RUN); else passed++;
    next_cycle();
    set_idle();
    @(negedge CLK);
    total++; if (obs() !== V_HALT) $display("FAIL halt_enter: got %b want %b", obs(), V_HALT); else passed++;
`ifdef PERF_CNT_EN
    c0 = cycle_cnt;
`endif
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      hif.ex_redirect = 1'b1; hif.ihit = i[0]; hif.mem_dREN = 1'b1;
      @(negedge CLK);
      total++; if (obs() !== V_HALT) $display("FAIL halt_sticky%0d: got %b want %b", i, obs(), V_HALT); else passed++;
      next_cycle();
    end
`ifdef PERF_CNT_EN
    @(negedge CLK);
    total++; if (cycle_cnt !== c0) $display("FAIL halt_cycle_cnt: got %0d want %0d", cycle_cnt, c0); else passed++;
`endif
    set_idle();
  endtask

  task automatic test_random();
    logic m_halted, m_pend, m_seen, dw, rd;
    logic [9:0] exp_v;
    for (int chunk = 0; chunk < 20; chunk++) begin
      nRST = 1'b0;
      @(negedge CLK);
      total++; if (obs() !== V_RST) $display("FAIL rand_reset%0d: got %b want %b", chunk, obs(), V_RST); else passed++;
      next_cycle();
      nRST = 1'b1;
      m_halted = 1'b0; m_pend = 1'b0; m_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        hif.ihit        = ($urandom % 4) != 0;
        hif.dhit        = ($urandom % 3) != 0;
        hif.mem_dREN    = ($urandom % 4) == 0;
        hif.mem_dWEN    = ($urandom % 6) == 0;
        hif.ex_dREN     = ($urandom % 2) == 0;
        hif.ex_WEN      = ($urandom % 4) != 0;
        hif.ex_wsel     = 5'($urandom_range(3, 0));
        hif.id_rs       = 5'($urandom_range(3, 0));
        hif.id_rt       = 5'($urandom_range(3, 0));
        hif.id_uses_rt  = ($urandom % 2) == 0;
        hif.ex_redirect = ($urandom % 6) == 0;
        hif.mem_halt    = ($urandom % 60) == 0;
        @(negedge CLK);
        exp_v = model_out(m_halted, m_pend, m_seen);
        total++;
        if (obs() !== exp_v) $display("FAIL rand_c%0d_i%0d: got %b want %b", chunk, i, obs(), exp_v);
        else passed++;
        dw = (hif.mem_dREN || hif.mem_dWEN) && !hif.dhit;
        rd = hif.ex_redirect || m_pend || m_seen;
        if (!m_halted) begin
          if (dw) begin
            m_seen = m_seen || hif.ex_redirect;
          end else if (hif.mem_halt) begin
            m_halted = 1'b1; m_pend = 1'b0; m_seen = 1'b0;
          end else if (rd) begin
            m_pend = !hif.ihit; m_seen = 1'b0;
          end
        end
        next_cycle();
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    nRST = 1'b0;
    #1;
    test_reset();
    test_load_use();
    test_fetch_wait();
    test_data_wait();
    test_redirect_pend();
    test_redirect_load_use();
    test_redirect_in_dwait();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
